// File: rtl/shift_sequence_ctrl.sv
// -----------------------------------------------------------------------------
// shift_sequence_ctrl
//
// Control FSM for the one-hot shift datapath. Each run issues one load pulse,
// then paces shift pulses with a programmable tick divider. It tracks the
// one-hot bit position internally so it can steer a bounce (ping-pong) pattern.
// The run ends when the datapath raises done.
//
// Parameters
//   WIDTH    : datapath register width; position wraps modulo WIDTH (>= 2)
//   CYCLES   : shifts per run (the run end itself comes from done)
//   TICK_DIV : idle WAIT cycles between shift pulses (>= 1)
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   level, sampled in IDLE to begin a run
//   stop        in   level, aborts any active run
//   repeat_en   in   level, sampled in FINISH to auto-restart
//   mode        in   0 left, 1 right, 2 bounce, 3 left; latched on leaving IDLE
//   done        in   registered run-complete flag from the datapath
//   load        out  one-cycle load pulse
//   shift_left  out  one-cycle shift pulse
//   shift_right out  one-cycle shift pulse, exclusive with shift_left
//   busy        out  high in every state except IDLE
//   run_done    out  one-cycle pulse when a run completes
//   run_count   out  completed runs, wraps 255 -> 0
//   position    out  current one-hot bit index
// -----------------------------------------------------------------------------
module shift_sequence_ctrl #(
  parameter int WIDTH    = 8,
  parameter int CYCLES   = 18,
  parameter int TICK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     repeat_en,
  input  logic [1:0]               mode,
  input  logic                     done,
  output logic                     load,
  output logic                     shift_left,
  output logic                     shift_right,
  output logic                     busy,
  output logic                     run_done,
  output logic [7:0]               run_count,
  output logic [$clog2(WIDTH)-1:0] position
);

  localparam int PW = $clog2(WIDTH);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] POS_MAX     = PW'(WIDTH - 1);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);

  if (WIDTH < 2 || CYCLES < 1 || TICK_DIV < 1) begin : g_param_check
    $error("shift_sequence_ctrl: requires WIDTH >= 2, CYCLES >= 1, TICK_DIV >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_SHIFT,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    MODE_LEFT,
    MODE_RIGHT,
    MODE_BOUNCE,
    MODE_LEFT_ALT
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  state_e          state_q, state_d;
  mode_e           mode_q;
  dir_e            dir_q;
  logic [TW-1:0]   tick_q;
  logic [PW-1:0]   pos_next;

  // State register.
  // NOTE: every clocked process assigns with <= so all registers sample the
  // same pre-edge values; a blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    shift_left  = 1'b0;
    shift_right = 1'b0;
    run_done    = 1'b0;
    busy        = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (!stop && start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (stop)                state_d = ST_IDLE;
        else if (done)           state_d = ST_FINISH;
        else if (tick_q == '0)   state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The pulse is Moore-decoded, so it still occurs when stop aborts here.
        shift_left  = (dir_q == DIR_LEFT);
        shift_right = (dir_q == DIR_RIGHT);
        state_d     = stop ? ST_IDLE : ST_WAIT;
      end
      ST_FINISH: begin
        run_done = 1'b1;
        if (stop)           state_d = ST_IDLE;
        else if (repeat_en) state_d = ST_LOAD;
        else                state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Position after the pending shift, wrapping modulo WIDTH like the datapath.
  always_comb begin
    if (dir_q == DIR_LEFT) pos_next = (position == POS_MAX) ? '0 : position + 1'b1;
    else                   pos_next = (position == '0) ? POS_MAX : position - 1'b1;
  end

  // Run bookkeeping: tick divider, position tracker, direction and mode latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q    <= '0;
      position  <= '0;
      dir_q     <= DIR_LEFT;
      mode_q    <= MODE_LEFT;
      run_count <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!stop && start) mode_q <= mode_e'(mode);
        end
        ST_LOAD: begin
          tick_q   <= TICK_RELOAD;
          position <= '0;
          dir_q    <= (mode_q == MODE_RIGHT) ? DIR_RIGHT : DIR_LEFT;
        end
        ST_WAIT: begin
          if (!stop && !done && tick_q != '0) tick_q <= tick_q - 1'b1;
        end
        ST_SHIFT: begin
          position <= pos_next;
          tick_q   <= TICK_RELOAD;
          // Bounce turns around at the ends, judged on the post-shift position,
          // so the datapath never wraps in this mode.
          if (mode_q == MODE_BOUNCE) begin
            if (pos_next == POS_MAX)  dir_q <= DIR_RIGHT;
            else if (pos_next == '0)  dir_q <= DIR_LEFT;
          end
        end
        ST_FINISH: begin
          run_count <= run_count + 8'd1;
          if (!stop && repeat_en) mode_q <= mode_e'(mode);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequence_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_sequence_ctrl
//
// Directed bench for shift_sequence_ctrl. A small datapath model supplies done
// (registered, cleared by load, set on the CYCLES-th shift). Expected shift
// pulses (direction, post-shift position, cycle offset from load) are queued
// when a run is launched and popped by a monitor as pulses appear.
// A second instance with TICK_DIV=1 checks the short-divider timing.
// -----------------------------------------------------------------------------
module tb_shift_sequence_ctrl;

  localparam int WIDTH    = 8;
  localparam int CYCLES   = 18;
  localparam int TICK_DIV = 4;
  localparam int PER      = TICK_DIV + 1;
  localparam int RUN_LEN  = 1 + CYCLES * PER + 1;
  localparam int PW       = $clog2(WIDTH);

  typedef struct packed {
    logic          left;
    logic [PW-1:0] pos;
    logic [31:0]   offset;
  } shift_exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  logic          start     = 1'b0;
  logic          stop      = 1'b0;
  logic          repeat_en = 1'b0;
  logic [1:0]    mode      = 2'd0;
  logic          done;
  logic          load, shift_left, shift_right, busy, run_done;
  logic [7:0]    run_count;
  logic [PW-1:0] position;

  logic          start2 = 1'b0;
  logic          done2;
  logic          load2, shift_left2, shift_right2, busy2, run_done2;
  logic [7:0]    run_count2;
  logic [PW-1:0] position2;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int last_load = 0, last_done = 0;
  int n_load = 0, n_done = 0, n_shift = 0, n_left = 0, n_shift2 = 0;
  logic          pos_pending = 1'b0;
  logic [PW-1:0] pend_pos    = '0;
  shift_exp_t    sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_sequence_ctrl #(.WIDTH(WIDTH), .CYCLES(CYCLES), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .repeat_en(repeat_en), .mode(mode), .done(done), .load(load),
    .shift_left(shift_left), .shift_right(shift_right), .busy(busy),
    .run_done(run_done), .run_count(run_count), .position(position)
  );

  shift_sequence_ctrl #(.WIDTH(WIDTH), .CYCLES(CYCLES), .TICK_DIV(1)) dut_fast (
    .clk(clk), .reset_n(reset_n), .start(start2), .stop(1'b0),
    .repeat_en(1'b0), .mode(2'd0), .done(done2), .load(load2),
    .shift_left(shift_left2), .shift_right(shift_right2), .busy(busy2),
    .run_done(run_done2), .run_count(run_count2), .position(position2)
  );

  // Datapath models: done registered, cleared by load, set by the last shift.
  int dp_cnt, dp_cnt2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_cnt <= 0;
      done   <= 1'b0;
    end else if (load) begin
      dp_cnt <= 0;
      done   <= 1'b0;
    end else if (shift_left || shift_right) begin
      dp_cnt <= dp_cnt + 1;
      if (dp_cnt + 1 == CYCLES) done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_cnt2 <= 0;
      done2   <= 1'b0;
    end else if (load2) begin
      dp_cnt2 <= 0;
      done2   <= 1'b0;
    end else if (shift_left2 || shift_right2) begin
      dp_cnt2 <= dp_cnt2 + 1;
      if (dp_cnt2 + 1 == CYCLES) done2 <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Queue the expected shift pulses of one run (first n shifts).
  function automatic void push_run(input logic [1:0] m, input int n);
    logic [PW-1:0] p = '0;
    logic go_left = (m != 2'd1);
    for (int k = 0; k < n; k++) begin
      shift_exp_t e;
      e.left = go_left;
      if (go_left) p = (p == PW'(WIDTH - 1)) ? '0 : p + 1'b1;
      else         p = (p == '0) ? PW'(WIDTH - 1) : p - 1'b1;
      if (m == 2'd2) begin
        if (p == PW'(WIDTH - 1)) go_left = 1'b0;
        else if (p == '0)        go_left = 1'b1;
      end
      e.pos    = p;
      e.offset = 32'((k + 1) * PER);
      sb_q.push_back(e);
    end
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboard on each pulse.
  always @(negedge clk) begin
    if (pos_pending) begin
      check("shift_position", 32'(position), 32'(pend_pos));
      pos_pending = 1'b0;
    end
    if (load) begin
      last_load = cyc;
      n_load++;
    end
    if (run_done) begin
      last_done = cyc;
      n_done++;
    end
    if (shift_left || shift_right) begin
      n_shift++;
      if (shift_left) n_left++;
      check("shift_exclusive", 32'(shift_left & shift_right), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_shift", 32'(sb_q.size()), 32'd1);
      end else begin
        shift_exp_t e;
        e = sb_q.pop_front();
        check("shift_dir_left", 32'(shift_left), 32'(e.left));
        check("shift_offset", 32'(cyc - last_load), e.offset);
        pend_pos    = e.pos;
        pos_pending = 1'b1;
      end
    end
    if (shift_left2 || shift_right2) n_shift2++;
  end

  // Step to just after the next falling edge (monitor has already run).
  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_run_done(input string tag, input int budget);
    int base = n_done;
    int k    = 0;
    while (n_done == base && k < budget) begin
      nstep();
      k++;
    end
    check(tag, 32'(n_done != base), 32'd1);
  endtask

  task automatic wait_shifts(input string tag, input int target, input int budget);
    int k = 0;
    while (n_shift < target && k < budget) begin
      nstep();
      k++;
    end
    check(tag, 32'(n_shift >= target), 32'd1);
  endtask

  task automatic launch(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    nstep();
    start = 1'b0;
  endtask

  initial begin
    #(200_000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_shift, base_load, base_left, base_done, k;

    // ---- Reset values (asynchronous) ----
    #1 reset_n = 1'b0;
    #1;
    check("reset_ctrl_outs", 32'({load, shift_left, shift_right, busy, run_done}), 32'd0);
    check("reset_run_count", 32'(run_count), 32'd0);
    check("reset_position", 32'(position), 32'd0);
    nstep();
    nstep();
    reset_n = 1'b1;
    nstep();
    check("idle_after_reset", 32'(busy), 32'd0);

    // ---- Basic left run ----
    push_run(2'd0, CYCLES);
    launch(2'd0);
    check("left_load_pulse", 32'({load, busy}), 32'b11);
    wait_run_done("left_run_done", 200);
    check("left_run_length", 32'(last_done - last_load), 32'(RUN_LEN));
    nstep();
    check("left_busy_falls", 32'(busy), 32'd0);
    check("left_run_count", 32'(run_count), 32'd1);
    check("left_position", 32'(position), 32'd2);
    check("left_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- Right run ----
    base_left = n_left;
    push_run(2'd1, CYCLES);
    launch(2'd1);
    wait_run_done("right_run_done", 200);
    nstep();
    check("right_position", 32'(position), 32'd6);
    check("right_no_left", 32'(n_left - base_left), 32'd0);
    check("right_run_count", 32'(run_count), 32'd2);

    // ---- Bounce run ----
    base_left = n_left;
    push_run(2'd2, CYCLES);
    launch(2'd2);
    wait_run_done("bounce_run_done", 200);
    nstep();
    check("bounce_position", 32'(position), 32'd4);
    check("bounce_left_count", 32'(n_left - base_left), 32'd11);
    check("bounce_run_count", 32'(run_count), 32'd3);
    check("bounce_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- Stop mid-run ----
    base_shift = n_shift;
    base_done  = n_done;
    push_run(2'd0, 5);
    launch(2'd0);
    wait_shifts("stop_five_shifts", base_shift + 5, 100);
    nstep();
    stop = 1'b1;
    nstep();
    check("stop_to_idle", 32'(busy), 32'd0);
    base_load = n_load;
    start = 1'b1;
    repeat (3) nstep();
    check("stop_start_stays_idle", 32'({busy, 1'b0}) | 32'(n_load - base_load), 32'd0);
    stop  = 1'b0;
    start = 1'b0;
    repeat (30) nstep();
    check("stop_no_more_shifts", 32'(n_shift - base_shift), 32'd5);
    check("stop_no_run_done", 32'(n_done - base_done), 32'd0);
    check("stop_run_count", 32'(run_count), 32'd3);

    // ---- Repeat: three runs, mode changed between runs ----
    push_run(2'd0, CYCLES);
    push_run(2'd1, CYCLES);
    push_run(2'd2, CYCLES);
    repeat_en = 1'b1;
    launch(2'd0);
    mode = 2'd1;
    wait_run_done("rep1_run_done", 200);
    check("rep1_run_length", 32'(last_done - last_load), 32'(RUN_LEN));
    nstep();
    check("rep1_reload", 32'(load), 32'd1);
    mode = 2'd2;
    wait_run_done("rep2_run_done", 200);
    check("rep2_position", 32'(position), 32'd6);
    nstep();
    check("rep2_reload", 32'(load), 32'd1);
    repeat_en = 1'b0;
    mode      = 2'd0;
    wait_run_done("rep3_run_done", 200);
    nstep();
    check("rep3_stops", 32'({busy, load}), 32'd0);
    check("rep_run_count", 32'(run_count), 32'd6);
    check("rep_position", 32'(position), 32'd4);
    check("rep_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- Reset mid-run ----
    base_shift = n_shift;
    push_run(2'd0, CYCLES);
    launch(2'd0);
    wait_shifts("rst_three_shifts", base_shift + 3, 100);
    nstep();
    reset_n = 1'b0;
    #1;
    check("rst_ctrl_outs", 32'({load, shift_left, shift_right, busy, run_done}), 32'd0);
    check("rst_run_count", 32'(run_count), 32'd0);
    check("rst_position", 32'(position), 32'd0);
    sb_q.delete();
    nstep();
    nstep();
    reset_n = 1'b1;
    base_load = n_load;
    repeat (20) nstep();
    check("rst_stays_idle", 32'(busy), 32'd0);
    check("rst_no_load", 32'(n_load - base_load), 32'd0);

    // ---- TICK_DIV = 1 instance ----
    base_shift = n_shift2;
    start2 = 1'b1;
    nstep();
    start2 = 1'b0;
    check("fast_load_pulse", 32'(load2), 32'd1);
    k = 0;
    while (!run_done2 && k < 100) begin
      nstep();
      k++;
    end
    check("fast_run_length", 32'(k), 32'd38);
    check("fast_shift_count", 32'(n_shift2 - base_shift), 32'(CYCLES));
    nstep();
    check("fast_run_count", 32'(run_count2), 32'd1);
    check("fast_position", 32'(position2), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequence_ctrl.md
# shift_sequence_ctrl

Control FSM for the one-hot shift datapath (WIDTH-bit one-hot register, CYCLES-step run counter, `done` flag). Each run proceeds as follows:
- Issues one `load` pulse.
- Paces `shift_left`/`shift_right` pulses using a programmable tick divider.
- Tracks the one-hot bit position internally so it can steer a bounce (ping-pong) pattern.
- Ends the run when the datapath raises `done`.

It sits directly upstream of the datapath, drives its control inputs, and consumes its `done`.

## Interface
- `WIDTH`, 8: datapath register width; position counter wraps modulo WIDTH.
- `CYCLES`, 18: shifts per run; informational only, since run end is taken from `done`.
- `TICK_DIV`, 4: idle cycles between shift pulses; must be ≥1.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled in IDLE to begin a run.
- `stop`  in  1  level; aborts any active run.
- `repeat_en`  in  1  level; sampled in FINISH to auto-restart.
- `mode`  in  2  0 = left, 1 = right, 2 = bounce, 3 = treated as left; latched on leaving IDLE.
- `done`  in  1  from datapath; registered, cleared by `load`.
- `load`  out  1  one-cycle load pulse to datapath.
- `shift_left`  out  1  one-cycle shift pulse.
- `shift_right`  out  1  one-cycle shift pulse; never high together with `shift_left`.
- `busy`  out  1  high in every state except IDLE.
- `run_done`  out  1  one-cycle pulse when a run completes.
- `run_count`  out  8  completed runs; wraps 255→0.
- `position`  out  ceil(log2 WIDTH)  current one-hot bit index.

## Operation
- States: IDLE, LOAD, WAIT, SHIFT, FINISH. State register is async-reset to IDLE. Outputs are Moore-decoded from registered state/direction.
- **IDLE:**
  - `stop`=1 → stay in IDLE.
  - Otherwise `start`=1 → LOAD, and latch `mode` into mode_q.
- **LOAD:**
  - `load`=1.
  - Reset tick counter to TICK_DIV-1.
  - `position` ← 0.
  - Direction flag ← right if mode_q=1, else left.
  - Next state: WAIT.
- **WAIT:** priority order:
  1. `stop` → IDLE.
  2. `done` → FINISH.
  3. Tick counter = 0 → SHIFT.
  4. Otherwise decrement tick counter.
- **SHIFT:**
  - Assert `shift_left` or `shift_right` according to the direction flag.
  - Update `position` (+1 for left, −1 for right, modulo WIDTH).
  - Reload tick counter to TICK_DIV-1.
  - Next state: WAIT.
  - `stop` in SHIFT → IDLE. The pulse still occurs this cycle.
- **Bounce (mode_q=2):** the direction flag is evaluated on each SHIFT against the new position.
  - New position = WIDTH-1 → flag ← right.
  - New position = 0 → flag ← left.
  - As a result, the datapath's own wrap is never exercised.
- **Left/right modes:** the direction flag is fixed. `position` wraps like the datapath (right from 0 → WIDTH-1).
- **FINISH:**
  - `run_done`=1.
  - `run_count` increments.
  - Next state: `stop` → IDLE; else `repeat_en` → LOAD with `mode` re-latched; else IDLE.
- An abort via `stop` never increments `run_count` or pulses `run_done`.
- `start` held high in IDLE after completion re-triggers a run. It is level-sensitive, not edge-sensitive.

## Timing
- Reset values (`reset_n`=0, immediate):
  - State IDLE.
  - `load`, `shift_left`, `shift_right`, `busy`, `run_done` = 0.
  - `run_count` = 0, `position` = 0, tick counter = 0, mode_q = 0.
- Reset mid-run: all outputs drop asynchronously. Nothing resumes after release until `start`.
- `start` sampled at edge E0 → `load` high in cycle E0..E1 → first WAIT cycle E1..E2.
- First shift pulse starts at edge E0+1+TICK_DIV. Subsequent pulses are spaced TICK_DIV+1 cycles apart.
- `done` is checked in the first WAIT cycle after each shift. FINISH follows one cycle after `done` is seen.
- Run length from LOAD entry to FINISH entry: 1 + CYCLES·(TICK_DIV+1) + 1 cycles. This is 92 for the defaults.
- `busy` rises one cycle after `start` is sampled and falls on return to IDLE.

## Test plan
- **Basic left run.** Defaults, mode=0, `start` pulse:
  - One `load`, then 18 `shift_left` pulses 5 cycles apart.
  - `run_done` at LOAD-entry+92.
  - `run_count`=1, `position`=2 (18 mod 8), `busy` falls the next cycle.
- **Right mode.** mode=1:
  - First shift is `shift_right` with `position`=7.
  - After 18 shifts, `position`=6.
  - `shift_left` is never asserted.
- **Bounce.** mode=2:
  - Shift sequence is 7 left, 7 right, 4 left.
  - `position` trace: 1..7, 6..0, 1..4. Final `position`=4, `run_count`=1.
- **Stop mid-run.** Assert `stop` during WAIT after the 5th shift:
  - IDLE next edge, no further shifts.
  - `run_done` never pulses, `run_count` unchanged.
  - `stop`+`start` together in IDLE → stays IDLE.
- **Repeat.** `repeat_en`=1 for 3 runs:
  - `load` recurs in the cycle after each `run_done`.
  - `run_count` reaches 3.
  - Changing `mode` between runs takes effect at the next LOAD.
- **Reset mid-run.** Drop `reset_n` mid-WAIT:
  - All outputs go to 0 asynchronously, `run_count`=0.
  - After release, the block stays in IDLE with `start`=0.
  - Also run with TICK_DIV=1: shifts every 2 cycles, run length 38.
